mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LS    = 1'b1;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - winner select; fixed priority, or round-robin when MEM_ARB_RR_EN is defined
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       fire,
`endif
  input  logic [1:0] req,
  output logic       valid,
  output logic       win
);

  assign valid = |req;

`ifdef MEM_ARB_RR_EN
  logic last;

  // Reset to "fetch granted last" so load/store wins the first contest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= REQ_FETCH;
    end else if (fire) begin
      last <= win;
    end
  end

  assign win = (&req) ? ~last : req[1];
`else
  assign win = req[1];
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-port data memory arbiter; MEM_ARB_RR_EN selects round-robin
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [5:0]  funct3,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic [31:0] rdata,
  output logic        dm_read,
  output logic        dm_write,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wrd,
  output logic [2:0]  dm_funct3,
  input  logic [31:0] dm_rdd
);

  state_t      state;
  logic        win;
  logic        any_req;
  logic        fire;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_f3;
  logic        lat_we;
  logic        lat_win;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_f3;

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk   (clk),
    .rst   (rst),
    .fire  (fire),
`endif
    .req   (req),
    .valid (any_req),
    .win   (win)
  );

  // Grant is combinational so the requester sees it in the same cycle it asks.
  assign fire = !rst && (state == IDLE) && any_req;
  assign gnt  = fire ? onehot(win) : 2'b00;

  assign sel_we    = win ? we[1]         : we[0];
  assign sel_addr  = win ? addr[63:32]   : addr[31:0];
  assign sel_wdata = win ? wdata[63:32]  : wdata[31:0];
  assign sel_f3    = win ? funct3[5:3]   : funct3[2:0];

  assign dm_addr   = lat_addr;
  assign dm_wrd    = lat_wdata;
  assign dm_funct3 = lat_f3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_win   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_f3    <= '0;
      dm_read   <= 1'b0;
      dm_write  <= 1'b0;
      rvalid    <= 2'b00;
      rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          rvalid <= 2'b00;
          if (fire) begin
            lat_we    <= sel_we;
            lat_win   <= win;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            lat_f3    <= sel_f3;
            dm_read   <= ~sel_we;
            dm_write  <= sel_we;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          dm_read  <= 1'b0;
          dm_write <= 1'b0;
          if (lat_we) begin
            state <= IDLE;
          end else begin
            // Memory read data is combinational, valid while dm_addr is held.
            rdata  <= dm_rdd;
            rvalid <= onehot(lat_win);
            state  <= RESP;
          end
        end
        RESP: begin
          rvalid <= 2'b00;
          state  <= IDLE;
        end
        default: begin
          dm_read  <= 1'b0;
          dm_write <= 1'b0;
          rvalid   <= 2'b00;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (both MEM_ARB_RR_EN builds)
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [5:0]  funct3;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [31:0] rdata;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wrd;
  logic [2:0]  dm_funct3;
  logic [31:0] dm_rdd;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  assign dm_rdd = mem[dm_addr[7:2]];

  always @(posedge clk) begin
    if (dm_write) mem[dm_addr[7:2]] = dm_wrd;
  end

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .funct3    (funct3),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .dm_read   (dm_read),
    .dm_write  (dm_write),
    .dm_addr   (dm_addr),
    .dm_wrd    (dm_wrd),
    .dm_funct3 (dm_funct3),
    .dm_rdd    (dm_rdd)
  );

  assert property (@(posedge clk) disable iff (rst) !(dm_read && dm_write))
    else $error("FAIL strobe_exclusive");
  assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
    else $error("FAIL gnt_onehot0");
  assert property (@(posedge clk) disable iff (rst) $onehot0(rvalid))
    else $error("FAIL rvalid_onehot0");

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((dm_read && dm_write) || !$onehot0(gnt) || !$onehot0(rvalid)) begin
        errors++;
        $display("FAIL invariant: rd=%b wr=%b gnt=%b rvalid=%b", dm_read, dm_write, gnt, rvalid);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; req = 2'b00; we = 2'b00; addr = '0; wdata = '0; funct3 = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    #1;
    checks++;
    if ({gnt, rvalid, dm_read, dm_write} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got gnt=%b rvalid=%b rd=%b wr=%b, want all 0", gnt, rvalid, dm_read, dm_write);
    end
    checks++;
    if ({rdata, dm_addr, dm_wrd, dm_funct3} !== 99'b0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h addr=%h wrd=%h f3=%b, want 0", rdata, dm_addr, dm_wrd, dm_funct3);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_req: gnt got %b want 00", gnt);
    end
  endtask

  task automatic test_read();
    mem[4] = 32'h11223344;
    req = 2'b01; we = 2'b00; addr = {32'h0, 32'h10}; funct3 = {LW, LW};
    #1;
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL read_gnt: got %b want 01", gnt); end
    @(negedge clk);
    checks++;
    if ({dm_read, dm_write, dm_addr, dm_funct3} !== {1'b1, 1'b0, 32'h10, LW}) begin
      errors++;
      $display("FAIL read_access: got rd=%b wr=%b addr=%h f3=%b want 1 0 10 %b", dm_read, dm_write, dm_addr, dm_funct3, LW);
    end
    req = 2'b00;
    @(negedge clk);
    checks++;
    if (rvalid !== 2'b01 || rdata !== 32'h11223344 || dm_read !== 1'b0) begin
      errors++;
      $display("FAIL read_resp: got rvalid=%b rdata=%h rd=%b want 01 11223344 0", rvalid, rdata, dm_read);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 2'b00 || rdata !== 32'h11223344) begin
      errors++;
      $display("FAIL read_hold: got rvalid=%b rdata=%h want 00 11223344", rvalid, rdata);
    end
  endtask

  task automatic test_write();
    req = 2'b10; we = 2'b10; addr = {32'h20, 32'h0}; wdata = {32'hDEADBEEF, 32'h0}; funct3 = {SW, LW};
    #1;
    checks++;
    if (gnt !== 2'b10) begin errors++; $display("FAIL write_gnt: got %b want 10", gnt); end
    @(negedge clk);
    checks++;
    if ({dm_write, dm_read, dm_addr, dm_wrd, dm_funct3} !== {1'b1, 1'b0, 32'h20, 32'hDEADBEEF, SW}) begin
      errors++;
      $display("FAIL write_access: got wr=%b rd=%b addr=%h wrd=%h f3=%b want 1 0 20 deadbeef %b", dm_write, dm_read, dm_addr, dm_wrd, dm_funct3, SW);
    end
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL gnt_in_access: got %b want 00", gnt); end
    req = 2'b00; we = 2'b00;
    @(negedge clk);
    checks++;
    if (dm_write !== 1'b0 || rvalid !== 2'b00 || mem[8] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_done: got wr=%b rvalid=%b mem=%h want 0 00 deadbeef", dm_write, rvalid, mem[8]);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 2'b00) begin errors++; $display("FAIL write_no_rvalid: got %b want 00", rvalid); end
  endtask

  task automatic test_arbitration();
    logic [1:0] exp [4];
`ifdef MEM_ARB_RR_EN
    exp = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    exp = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem[1] = 32'hA0A0A0A0; mem[2] = 32'hB1B1B1B1;
    req = 2'b11; we = 2'b00; addr = {32'h8, 32'h4}; funct3 = {LW, LW};
    for (int g = 0; g < 4; g++) begin
      int waited;
      waited = 0;
      #1;
      while (gnt === 2'b00 && waited < 6) begin
        @(negedge clk); #1;
        waited++;
      end
      checks++;
      if (gnt !== exp[g]) begin
        errors++;
        $display("FAIL arb_grant%0d: got %b want %b (waited %0d)", g, gnt, exp[g], waited);
      end
      @(negedge clk);
    end
    req = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    mem[5] = 32'h55667788;
    req = 2'b01; we = 2'b00; addr = {32'h0, 32'h14}; funct3 = {LW, LW};
    @(negedge clk);
    req = 2'b00;
    checks++;
    if (dm_read !== 1'b1) begin errors++; $display("FAIL abort_setup: dm_read got %b want 1", dm_read); end
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, rvalid, dm_read, dm_write, rdata, dm_addr, dm_wrd, dm_funct3} !== 105'b0) begin
      errors++;
      $display("FAIL abort_outputs: gnt=%b rvalid=%b rd=%b wr=%b rdata=%h addr=%h want all 0", gnt, rvalid, dm_read, dm_write, rdata, dm_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid !== 2'b00) begin errors++; $display("FAIL abort_no_rvalid: got %b want 00", rvalid); end
    req = 2'b01;
    #1;
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL abort_regrant: got %b want 01", gnt); end
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    checks++;
    if (rvalid !== 2'b01 || rdata !== 32'h55667788) begin
      errors++;
      $display("FAIL abort_recover: got rvalid=%b rdata=%h want 01 55667788", rvalid, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_input_hold();
    mem[12] = 32'hCAFEF00D; mem[16] = 32'h0BADBEEF;
    req = 2'b01; we = 2'b00; addr = {32'h0, 32'h30}; funct3 = {LW, LBU};
    #1;
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL hold_gnt: got %b want 01", gnt); end
    @(posedge clk);
    #1;
    req = 2'b00; addr = {32'h0, 32'h40}; funct3 = {LW, LW}; we = 2'b01;
    @(negedge clk);
    checks++;
    if (dm_addr !== 32'h30 || dm_funct3 !== LBU || dm_read !== 1'b1 || dm_write !== 1'b0) begin
      errors++;
      $display("FAIL hold_access: got addr=%h f3=%b rd=%b wr=%b want 30 %b 1 0", dm_addr, dm_funct3, dm_read, dm_write, LBU);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 2'b01 || rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL hold_resp: got rvalid=%b rdata=%h want 01 cafef00d", rvalid, rdata);
    end
    we = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_arbitration();
    test_reset_mid();
    test_input_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
